// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit
//
// Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on registered operands.
// Multiplies are 32 shift-add steps and divides are 32 restoring steps.
// Divide by zero and signed overflow skip the iteration (short path).
// Optional macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle product
// and also take the short path.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-high reset
//   instr_i    instruction word (opcode, rd, funct3, funct7 decoded here)
//   rs1_i      source operand 1 (multiplicand / dividend)
//   rs2_i      source operand 2 (multiplier / divisor)
//   valid_i    request present
//   ready_o    unit idle and able to accept a request
//   rd_data_o  result
//   rd_addr_o  destination register of the result
//   valid_o    result present, held until ready_i
//   ready_i    write-back consumes result
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic [4:0]      rd_addr_o,
    output logic            valid_o,
    input  logic            ready_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_funct3;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [2*XLEN-1:0] r_acc;
    logic [5:0]        r_cnt;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_valid;
    logic [XLEN-1:0]   r_rd_data;

    // Request decode
    logic [2:0]      w_f3;
    logic            w_is_m;
    logic            w_accept;
    logic            w_is_div;
    logic            w_s1;
    logic            w_s2;
    logic            w_n1;
    logic            w_n2;
    logic [XLEN-1:0] w_m1;
    logic [XLEN-1:0] w_m2;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_short;
    logic            w_unused;

    assign w_f3     = instr_i[14:12];
    assign w_is_m   = (instr_i[6:0] == 7'b0110011) && (instr_i[31:25] == 7'b0000001);
    assign w_accept = valid_i && (r_state == S_IDLE) && w_is_m;
    assign w_is_div = w_f3[2];
    assign w_unused = ^instr_i[24:15];

    // Operand signedness: divides are signed when funct3[0] is clear;
    // multiplies treat rs1 signed except MULHU, rs2 signed for MUL/MULH only.
    assign w_s1 = w_is_div ? ~w_f3[0] : ~(w_f3[1] & w_f3[0]);
    assign w_s2 = w_is_div ? ~w_f3[0] : ~w_f3[1];
    assign w_n1 = w_s1 & rs1_i[XLEN-1];
    assign w_n2 = w_s2 & rs2_i[XLEN-1];
    assign w_m1 = w_n1 ? -rs1_i : rs1_i;
    assign w_m2 = w_n2 ? -rs2_i : rs2_i;

    assign w_div_zero = w_is_div && (rs2_i == '0);
    assign w_div_ovf  = w_is_div && !w_f3[0] && (rs1_i == {1'b1, {(XLEN-1){1'b0}}})
                        && (rs2_i == {XLEN{1'b1}});

`ifdef MULDIV_FAST_MUL_EN
    // Operands extended to the full product width; the low 2*XLEN bits of
    // the product equal those of the 33x33 signed product.
    logic [2*XLEN-1:0] w_fa;
    logic [2*XLEN-1:0] w_fb;
    logic [2*XLEN-1:0] w_fast_prod;
    assign w_fa        = {{XLEN{w_s1 & rs1_i[XLEN-1]}}, rs1_i};
    assign w_fb        = {{XLEN{w_s2 & rs2_i[XLEN-1]}}, rs2_i};
    assign w_fast_prod = w_fa * w_fb;
    assign w_short     = w_div_zero || w_div_ovf || !w_is_div;
`else
    assign w_short     = w_div_zero || w_div_ovf;
`endif

    // Multiply step: accumulator holds {partial product, remaining multiplier}.
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_nxt;
    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : {(XLEN+1){1'b0}});
    assign w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};

    // Restoring divide step: accumulator holds {remainder, dividend/quotient}.
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_rem_diff;
    logic [2*XLEN-1:0] w_div_nxt;
    assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
    assign w_rem_diff = w_rem_sh - {1'b0, r_b};
    assign w_div_nxt  = w_rem_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                         : {w_rem_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    // Sign fix-up and result select
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_result;
    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quot = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_result = w_prod[2*XLEN-1:XLEN];
        if (r_funct3[2])
            w_result = r_funct3[1] ? w_rem : w_quot;
        else if (r_funct3[1:0] == 2'b00)
            w_result = w_prod[XLEN-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_short ? S_DONE : S_BUSY;
            S_BUSY:  if (r_cnt == 6'd32) w_state_nxt = S_DONE;
            S_DONE:  if (r_valid && ready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Short-path operations pre-load the accumulator with the final
    // {remainder, quotient} or product and clear the sign flags, so the one
    // result mux serves both paths. DONE without r_valid is the cycle that
    // registers that result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_funct3  <= '0;
            r_rd      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_valid   <= 1'b0;
            r_rd_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_funct3 <= w_f3;
                        r_rd     <= instr_i[11:7];
                        r_a      <= w_m1;
                        r_b      <= w_m2;
                        r_cnt    <= '0;
                        r_neg_q  <= w_n1 ^ w_n2;
                        r_neg_r  <= w_n1;
                        r_acc    <= {{XLEN{1'b0}}, (w_is_div ? w_m1 : w_m2)};
                        if (w_div_zero) begin
                            r_acc   <= {rs1_i, {XLEN{1'b1}}};
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else if (w_div_ovf) begin
                            r_acc   <= {{XLEN{1'b0}}, rs1_i};
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!w_is_div) begin
                            r_acc   <= w_fast_prod;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end
`endif
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd32) begin
                        r_rd_data <= w_result;
                        r_valid   <= 1'b1;
                    end else begin
                        r_acc <= r_funct3[2] ? w_div_nxt : w_mul_nxt;
                    end
                end
                S_DONE: begin
                    if (!r_valid) begin
                        r_rd_data <= w_result;
                        r_valid   <= 1'b1;
                    end else if (ready_i) begin
                        r_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_o   = (r_state == S_IDLE);
    assign valid_o   = r_valid;
    assign rd_data_o = r_rd_data;
    assign rd_addr_o = r_rd;

endmodule
